// File: rtl/mx_pkg.sv
// Shared definitions for the block-floating-point dot-product accumulator.
//   scale_w   : width of every power-of-two exponent field
//   state_e   : accumulator control states (ACC -> NORM -> OUT)
//   sat_add8  : unsigned exponent add that clamps at the field maximum
package mx_pkg;

  localparam int scale_w = 8;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_NORM = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  function automatic logic [scale_w-1:0] sat_add8(input logic [scale_w-1:0] a,
                                                  input logic [scale_w-1:0] b);
    logic [scale_w:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[scale_w] ? {scale_w{1'b1}} : s[scale_w-1:0];
  endfunction

endpackage

// File: rtl/mx_dot_accum_if.sv
// Beat/result channels of mx_dot_accum.
//   upstream  : i_valid / o_ready handshake carrying i_dp @ i_scale, i_last
//   downstream: o_valid / i_ready handshake carrying o_dp @ o_scale, o_count
// slave is the accumulator side, master is the side that feeds and drains it.
interface mx_dot_accum_if
  import mx_pkg::*;
#(
  parameter int in_width  = 8,
  parameter int out_width = 8
);

  logic                        i_valid;
  logic                        o_ready;
  logic signed [in_width-1:0]  i_dp;
  logic        [scale_w-1:0]   i_scale;
  logic                        i_last;

  logic                        o_valid;
  logic                        i_ready;
  logic signed [out_width-1:0] o_dp;
  logic        [scale_w-1:0]   o_scale;
  logic        [scale_w-1:0]   o_count;

  modport slave (
    input  i_valid, i_dp, i_scale, i_last, i_ready,
    output o_ready, o_valid, o_dp, o_scale, o_count
  );

  modport master (
    output i_valid, i_dp, i_scale, i_last, i_ready,
    input  o_ready, o_valid, o_dp, o_scale, o_count
  );

endinterface

// File: rtl/lead_sign_shift.sv
// Right-normaliser: finds the smallest n for which x >>> n is representable
// as an out_w-bit signed value, and returns that shifted value.
//   x : signed in_w-bit input
//   y : x >>> n truncated to out_w bits (lossless in the kept range)
//   n : shift amount, 0 .. in_w-out_w
module lead_sign_shift
  import mx_pkg::*;
#(
  parameter int in_w  = 24,
  parameter int out_w = 8
) (
  input  logic signed [in_w-1:0]  x,
  output logic signed [out_w-1:0] y,
  output logic        [scale_w-1:0] n
);

  function automatic logic fits(input logic signed [in_w-1:0] v);
    logic signed [out_w-1:0] lo;
    logic signed [in_w-1:0]  ext;
    lo  = v[out_w-1:0];
    ext = lo;
    return ext == v;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a value before any branch so no latch is inferred.
    n = scale_w'(in_w - out_w);
    // Walk from the largest shift down; the last fitting shift is the minimum.
    for (int k = in_w - out_w; k >= 0; k--) begin
      if (fits(x >>> k)) n = scale_w'(k);
    end
    y = out_w'(x >>> n);
  end

endmodule

// File: rtl/mx_dot_accum.sv
// Block-floating-point accumulator: sums a group of signed mantissa beats,
// each with its own power-of-two exponent, then right-normalises the sum
// to out_width bits and presents it with its exponent and beat count.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   bus     : slave side of mx_dot_accum_if (beat input, result output)
module mx_dot_accum
  import mx_pkg::*;
#(
  parameter int in_width  = 8,
  parameter int acc_width = 24,
  parameter int out_width = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mx_dot_accum_if.slave  bus
);

  state_e                       state_q, state_d;
  logic signed [acc_width-1:0]  acc_q, acc_d;
  logic        [scale_w-1:0]    acc_scale_q, acc_scale_d;
  logic                         empty_q;
  logic        [scale_w-1:0]    count_q;
  logic signed [out_width-1:0]  dp_q;
  logic        [scale_w-1:0]    scale_q;

  logic                         ready_int;
  logic                         accept;
  logic signed [acc_width-1:0]  in_ext, a_op, b_op;
  logic        [scale_w-1:0]    sh, scale_big;
  logic        [acc_width:0]    sum;
  logic signed [out_width-1:0]  norm_dp;
  logic        [scale_w-1:0]    norm_n;

  // Arithmetic right shift where any shift past the full width leaves only sign.
  function automatic logic signed [acc_width-1:0] shr_sat(input logic signed [acc_width-1:0] v,
                                                          input logic [scale_w-1:0] s);
    if (int'(s) >= acc_width) return {acc_width{v[acc_width-1]}};
    return v >>> s;
  endfunction

  assign accept = bus.i_valid && ready_int;
  assign in_ext = {{(acc_width-in_width){bus.i_dp[in_width-1]}}, bus.i_dp};

  // Exponent alignment and one-extra-bit add; overflow is absorbed by a
  // single right shift with the exponent bumped.
  always_comb begin
    a_op        = acc_q;
    b_op        = in_ext;
    scale_big   = acc_scale_q;
    sh          = '0;
    acc_d       = acc_q;
    acc_scale_d = acc_scale_q;
    if (acc_scale_q >= bus.i_scale) begin
      sh   = acc_scale_q - bus.i_scale;
      b_op = shr_sat(in_ext, sh);
    end else begin
      sh        = bus.i_scale - acc_scale_q;
      a_op      = shr_sat(acc_q, sh);
      scale_big = bus.i_scale;
    end
    sum = {a_op[acc_width-1], a_op} + {b_op[acc_width-1], b_op};
    if (empty_q) begin
      acc_d       = in_ext;
      acc_scale_d = bus.i_scale;
    end else if (sum[acc_width] == sum[acc_width-1]) begin
      acc_d       = sum[acc_width-1:0];
      acc_scale_d = scale_big;
    end else begin
      acc_d       = sum[acc_width:1];
      acc_scale_d = sat_add8(scale_big, 8'd1);
    end
  end

  lead_sign_shift #(
    .in_w  (acc_width),
    .out_w (out_width)
  ) u_lead_sign_shift (
    .x (acc_q),
    .y (norm_dp),
    .n (norm_n)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_rst_n) state_q <= ST_ACC;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACC:  if (accept && bus.i_last) state_d = ST_NORM;
      ST_NORM: state_d = ST_OUT;
      ST_OUT:  if (bus.i_ready) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready_int   = (state_q == ST_ACC);
    bus.o_ready = ready_int;
    bus.o_valid = (state_q == ST_OUT);
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q       <= '0;
      acc_scale_q <= '0;
      empty_q     <= 1'b1;
      count_q     <= '0;
      dp_q        <= '0;
      scale_q     <= '0;
    end else begin
      unique case (state_q)
        ST_ACC: begin
          if (accept) begin
            acc_q       <= acc_d;
            acc_scale_q <= acc_scale_d;
            empty_q     <= 1'b0;
            count_q     <= sat_add8(count_q, 8'd1);
          end
        end
        ST_NORM: begin
          dp_q    <= norm_dp;
          scale_q <= sat_add8(acc_scale_q, norm_n);
        end
        ST_OUT: begin
          if (bus.i_ready) begin
            acc_q       <= '0;
            acc_scale_q <= '0;
            empty_q     <= 1'b1;
            count_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_dp    = dp_q;
  assign bus.o_scale = scale_q;
  assign bus.o_count = count_q;

endmodule
